// File: rtl/count_seq_checker.sv
// Receive-side monitor for a free-running modulo-MOD counter: locks onto the legal
// sequence 0..MOD-1, flags out-of-sequence or illegal samples and counts errors and wraps.
module count_seq_checker #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned MOD    = 3,
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q,
  input  logic             q_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0] expected
);

  localparam int unsigned RunW = $clog2(LOCK_N + 1);
  // Largest legal value; fits in WIDTH bits even when the modulus equals 2**WIDTH.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);
  localparam logic [RunW-1:0]  LockN  = RunW'(LOCK_N);

  typedef enum logic [1:0] {StIdle, StSync, StLocked} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] wrap_count_q, wrap_count_d;

  logic             illegal;
  logic             match;
  logic [WIDTH-1:0] q_nxt;
  logic [RunW-1:0]  run_inc;
  logic             err_bump;
  logic             wrap_bump;

  assign illegal = (q > MaxVal);
  assign match   = (q == expected_q);
  assign q_nxt   = (q == MaxVal) ? '0 : q + 1'b1;
  assign run_inc = run_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    run_d      = run_q;
    err_bump   = 1'b0;
    wrap_bump  = 1'b0;

    if (q_valid) begin
      unique case (state_q)
        StIdle: begin
          if (illegal) begin
            err_bump = 1'b1;
          end else begin
            expected_d = q_nxt;
            run_d      = '0;
            state_d    = StSync;
          end
        end
        StSync: begin
          if (illegal) begin
            err_bump   = 1'b1;
            expected_d = '0;
            state_d    = StIdle;
          end else if (match) begin
            run_d      = run_inc;
            expected_d = q_nxt;
            if (run_inc == LockN) begin
              state_d = StLocked;
            end
          end else begin
            // Not locked yet, so a mismatch just restarts the run silently.
            run_d      = '0;
            expected_d = q_nxt;
          end
        end
        StLocked: begin
          if (illegal) begin
            err_bump   = 1'b1;
            expected_d = '0;
            state_d    = StIdle;
          end else if (match) begin
            expected_d = q_nxt;
            wrap_bump  = (q == '0);
          end else begin
            err_bump   = 1'b1;
            run_d      = '0;
            expected_d = q_nxt;
            state_d    = StSync;
          end
        end
        default: begin
          state_d    = StIdle;
          expected_d = '0;
          run_d      = '0;
        end
      endcase
    end

    err_d        = err_bump;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    if (err_bump && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
    if (wrap_bump && (wrap_count_q != '1)) begin
      wrap_count_d = wrap_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      expected_q   <= '0;
      run_q        <= '0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      run_q        <= run_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign locked     = (state_q == StLocked);
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: default instance for sequencing and reset,
// a CNT_W=2 instance for counter saturation.
module tb_count_seq_checker;

  logic       clk;
  logic       reset;
  logic [1:0] q;
  logic       q_valid;
  logic       locked;
  logic       err;
  logic [7:0] err_count;
  logic [7:0] wrap_count;
  logic [1:0] expected;

  logic [1:0] q_s;
  logic       q_valid_s;
  logic       locked_s;
  logic       err_s;
  logic [1:0] err_count_s;
  logic [1:0] wrap_count_s;
  logic [1:0] expected_s;

  int unsigned n_vec;
  int unsigned n_bad;

  count_seq_checker #(
    .WIDTH (2),
    .MOD   (3),
    .LOCK_N(3),
    .CNT_W (8)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .q         (q),
    .q_valid   (q_valid),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .wrap_count(wrap_count),
    .expected  (expected)
  );

  count_seq_checker #(
    .WIDTH (2),
    .MOD   (3),
    .LOCK_N(3),
    .CNT_W (2)
  ) u_dut_sat (
    .clk       (clk),
    .reset     (reset),
    .q         (q_s),
    .q_valid   (q_valid_s),
    .locked    (locked_s),
    .err       (err_s),
    .err_count (err_count_s),
    .wrap_count(wrap_count_s),
    .expected  (expected_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Drive a sample mid-cycle, let one rising edge take it, then settle.
  task automatic drive(input logic [1:0] qv, input logic vv);
    @(negedge clk);
    q       = qv;
    q_valid = vv;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sat(input logic [1:0] qv);
    @(negedge clk);
    q_s       = qv;
    q_valid_s = 1'b1;
    q_valid   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int unsigned lk, input int unsigned e,
                           input int unsigned ec, input int unsigned wc,
                           input int unsigned ex);
    check({tag, ".locked"}, locked, lk);
    check({tag, ".err"}, err, e);
    check({tag, ".err_count"}, err_count, ec);
    check({tag, ".wrap_count"}, wrap_count, wc);
    check({tag, ".expected"}, expected, ex);
  endtask

  initial begin
    logic [1:0] seq [9];
    int unsigned sat_exp [5];
    n_vec     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    q         = '0;
    q_valid   = 1'b0;
    q_s       = '0;
    q_valid_s = 1'b0;
    seq       = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    sat_exp   = '{1, 2, 3, 3, 3};

    #2;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Lock-in: locked rises only after the 4th correct sample.
    drive(2'd0, 1'b1); check_all("lock.s1", 0, 0, 0, 0, 1);
    drive(2'd1, 1'b1); check_all("lock.s2", 0, 0, 0, 0, 2);
    drive(2'd2, 1'b1); check_all("lock.s3", 0, 0, 0, 0, 0);
    drive(2'd0, 1'b1); check_all("lock.s4", 1, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      drive(seq[i], 1'b1);
      check("run.err", err, 0);
      check("run.locked", locked, 1);
    end
    check("run.wrap_count", wrap_count, 3);
    check("run.err_count", err_count, 0);

    // Sequence skip while expecting 1.
    drive(2'd2, 1'b1); check_all("skip", 0, 1, 1, 3, 0);
    drive(2'd0, 1'b1); check_all("skip.r1", 0, 0, 1, 3, 1);
    drive(2'd1, 1'b1); check_all("skip.r2", 0, 0, 1, 3, 2);
    drive(2'd2, 1'b1); check_all("skip.r3", 1, 0, 1, 3, 0);

    // Illegal value while locked.
    drive(2'd0, 1'b1); check_all("ill.pre", 1, 0, 1, 4, 1);
    drive(2'd3, 1'b1); check_all("ill", 0, 1, 2, 4, 0);
    drive(2'd0, 1'b1); check_all("ill.r1", 0, 0, 2, 4, 1);
    drive(2'd1, 1'b1); check_all("ill.r2", 0, 0, 2, 4, 2);
    drive(2'd2, 1'b1); check_all("ill.r3", 0, 0, 2, 4, 0);
    drive(2'd0, 1'b1); check_all("ill.r4", 1, 0, 2, 4, 1);

    // Stall: q_valid low with garbage on q changes nothing.
    drive(2'd3, 1'b0); check_all("stall1", 1, 0, 2, 4, 1);
    drive(2'd2, 1'b0); check_all("stall2", 1, 0, 2, 4, 1);
    drive(2'd3, 1'b0); check_all("stall3", 1, 0, 2, 4, 1);
    drive(2'd2, 1'b0); check_all("stall4", 1, 0, 2, 4, 1);
    drive(2'd3, 1'b0); check_all("stall5", 1, 0, 2, 4, 1);
    drive(2'd1, 1'b1); check_all("resume1", 1, 0, 2, 4, 2);
    drive(2'd2, 1'b1); check_all("resume2", 1, 0, 2, 4, 0);
    drive(2'd0, 1'b1); check_all("resume3", 1, 0, 2, 5, 1);

    // Async reset pulse between edges.
    #2;
    reset = 1'b1;
    #1;
    check_all("areset.hi", 0, 0, 0, 0, 0);
    #3;
    reset = 1'b0;
    #1;
    check_all("areset.lo", 0, 0, 0, 0, 0);
    drive(2'd0, 1'b1); check("relock.s1", locked, 0);
    drive(2'd1, 1'b1); check("relock.s2", locked, 0);
    drive(2'd2, 1'b1); check("relock.s3", locked, 0);
    drive(2'd0, 1'b1); check_all("relock.s4", 1, 0, 0, 0, 1);

    // Saturation on the 2-bit-counter instance, idle since the reset pulse.
    for (int i = 0; i < 5; i++) begin
      drive_sat(2'd3);
      check("sat.err", err_s, 1);
      check("sat.err_count", err_count_s, sat_exp[i]);
      check("sat.locked", locked_s, 0);
      check("sat.expected", expected_s, 0);
    end
    check("sat.main_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
